// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU operations and datapath mux selects (also used by the datapath bench).
package riscv_ctrl_defs;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
        S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ADR_PC  = 2'b00;
    localparam logic [1:0] ADR_RES = 2'b01;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    // Instruction class presented to the ALU decoder
    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_R    = 2'd1;
    localparam logic [1:0] CLS_I    = 2'd2;
    localparam logic [1:0] CLS_BR   = 2'd3;

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode from func3/func7 and instruction class; flags encodings
// the controller must trap on.
module alu_decoder
    import riscv_ctrl_defs::*;
(
    input  logic [2:0] i_func3,
    input  logic [6:0] i_func7,
    input  logic [1:0] i_class,
    output logic [2:0] o_alu_ctrl,
    output logic       o_illegal
);

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        o_illegal  = 1'b0;
        case (i_class)
            CLS_R, CLS_I: begin
                case (i_func3)
                    3'b000:  o_alu_ctrl = (i_class == CLS_R && i_func7[5]) ? ALU_SUB : ALU_ADD;
                    3'b111:  o_alu_ctrl = ALU_AND;
                    3'b110:  o_alu_ctrl = ALU_OR;
                    3'b010:  o_alu_ctrl = ALU_SLT;
                    default: o_illegal  = 1'b1;
                endcase
                // func7 is immediate bits for I-type, so only R-type checks it
                if (i_class == CLS_R && i_func7 != 7'h00 && i_func7 != 7'h20)
                    o_illegal = 1'b1;
            end
            CLS_BR: begin
                o_alu_ctrl = ALU_SUB;
                o_illegal  = !(i_func3 == 3'b000 || i_func3 == 3'b001 ||
                               i_func3 == 3'b100 || i_func3 == 3'b101);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main FSM of the multicycle RV32I core: sequences datapath selects/enables,
// traps on illegal encodings and counts retired instructions.
module multicycle_controller
    import riscv_ctrl_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             zero,
    input  logic             negative,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [1:0]       AdrSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [2:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t           r_state, w_next;
    logic             r_illegal_op;
    logic [CNT_W-1:0] r_instr_count;
    logic [1:0]       w_class;
    logic [2:0]       w_alu_dec;
    logic             w_alu_illegal;
    logic             w_pcw, w_irw, w_rw, w_mw, w_retire;

    always_comb begin
        case (r_state)
            S_EXEC_R: w_class = CLS_R;
            S_EXEC_I: w_class = CLS_I;
            S_BRANCH: w_class = CLS_BR;
            default:  w_class = CLS_NONE;
        endcase
    end

    alu_decoder u_alu_dec (
        .i_func3    (func3),
        .i_func7    (func7),
        .i_class    (w_class),
        .o_alu_ctrl (w_alu_dec),
        .o_illegal  (w_alu_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_FETCH;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_pcw      = 1'b0;
        w_irw      = 1'b0;
        w_rw       = 1'b0;
        w_mw       = 1'b0;
        w_retire   = 1'b0;
        AdrSrc     = ADR_PC;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_B;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        ImmSrc     = imm_src(opcode);
        case (r_state)
            S_FETCH: begin
                w_irw     = 1'b1;
                w_pcw     = 1'b1;
                ALUSrcB   = SRCB_4;
                ResultSrc = RES_ALU;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut still holds PC+4 here, so links are written this cycle
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                if (opcode == OP_JAL || opcode == OP_JALR) w_rw = 1'b1;
                case (opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXEC_R;
                    OP_I:              w_next = S_EXEC_I;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                w_next  = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = ADR_RES;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_MDR;
                w_rw      = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = ADR_RES;
                w_mw     = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = (r_state == S_EXEC_I) ? SRCB_IMM : SRCB_B;
                ALUControl = w_alu_dec;
                w_next     = w_alu_illegal ? S_TRAP : S_ALUWB;
            end
            S_ALUWB: begin
                w_rw     = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_A;
                ALUControl = ALU_SUB;
                if (w_alu_illegal) begin
                    w_next = S_TRAP;
                end else begin
                    case (func3)
                        3'b000:  w_pcw = zero;
                        3'b001:  w_pcw = !zero;
                        3'b100:  w_pcw = negative;
                        default: w_pcw = !negative;
                    endcase
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_JAL: begin
                w_pcw    = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_JALR: begin
                ALUSrcA   = SRCA_A;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                w_pcw     = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_LUI: begin
                ResultSrc = RES_IMM;
                w_rw      = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_illegal_op  <= 1'b0;
            r_instr_count <= '0;
        end else begin
            if (w_next == S_TRAP) r_illegal_op <= 1'b1;
            if (w_retire)         r_instr_count <= r_instr_count + 1'b1;
        end
    end

    assign PCWrite     = w_pcw & rst;
    assign IRWrite     = w_irw & rst;
    assign RegWrite    = w_rw & rst;
    assign MemWrite    = w_mw & rst;
    assign illegal_op  = r_illegal_op;
    assign instr_count = r_instr_count;

endmodule
